// File: rtl/wb_write_ctrl.sv
// rtl/wb_write_ctrl.sv - register file writeback arbiter for pipeline and mul/div results (optional WB_FWD_EN bypass)
module wb_write_ctrl #(
    parameter int DEPTH = 2,
    parameter int PTR_W = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_valid,
    input  logic        pipe_is_load,
    input  logic        pipe_lb,
    input  logic [3:0]  pipe_wa,
    input  logic [15:0] pipe_wd,
    input  logic        md_valid,
    output logic        md_ready,
    input  logic [3:0]  md_wa,
    input  logic [15:0] md_lo,
    input  logic [15:0] md_hi,
    input  logic [3:0]  RR1,
    input  logic [3:0]  RR2,
    output logic        hazard,
`ifdef WB_FWD_EN
    output logic        fwd1_hit,
    output logic        fwd2_hit,
    output logic [15:0] fwd1_data,
    output logic [15:0] fwd2_data,
`endif
    output logic        regWrite,
    output logic        wr_r0,
    output logic [3:0]  WA,
    output logic [15:0] WD1,
    output logic [15:0] WD0
);

    // pending mul/div results, one valid bit per slot
    logic [3:0]       ent_wa [DEPTH];
    logic [15:0]      ent_lo [DEPTH];
    logic [15:0]      ent_hi [DEPTH];
    logic [DEPTH-1:0] vld;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    logic             empty;
    logic             full;
    logic             pop;
    logic             push;
    logic [15:0]      pipe_data;
    logic [DEPTH-1:0] ent_hit;

    assign empty = ~|vld;
    assign full  = &vld;

    // the pipeline owns the write port; the FIFO drains only into idle slots
    assign pop      = !pipe_valid && !empty;
    assign md_ready = !full || pop;
    // a result that cannot go straight to the port waits in the FIFO
    assign push     = md_valid && md_ready && (pipe_valid || !empty);

    // byte loads are sign-extended; ALU results and word loads pass through
    assign pipe_data = (pipe_is_load && pipe_lb) ? {{8{pipe_wd[7]}}, pipe_wd[7:0]} : pipe_wd;

    // per-entry hazard match; any pending entry also makes R0 pending
    genvar g;
    generate
        for (g = 0; g < DEPTH; g++) begin : g_hit
            assign ent_hit[g] = vld[g] && (ent_wa[g] == RR1 || ent_wa[g] == RR2 ||
                                           RR1 == 4'd0 || RR2 == 4'd0);
        end
    endgenerate

    assign hazard = |ent_hit;

    // FIFO storage and pointers; pop clears before push sets so full+pop reuses the slot
    always_ff @(posedge clk) begin
        if (rst) begin
            vld    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (pop) begin
                vld[rd_ptr] <= 1'b0;
                rd_ptr      <= rd_ptr + 1'b1;
            end
            if (push) begin
                vld[wr_ptr]    <= 1'b1;
                ent_wa[wr_ptr] <= md_wa;
                ent_lo[wr_ptr] <= md_lo;
                ent_hi[wr_ptr] <= md_hi;
                wr_ptr         <= wr_ptr + 1'b1;
            end
        end
    end

    // registered write port: pipeline first, then FIFO head, then direct mul/div bypass
    always_ff @(posedge clk) begin
        if (rst) begin
            regWrite <= 1'b0;
            wr_r0    <= 1'b0;
            WA       <= 4'd0;
            WD1      <= 16'd0;
            WD0      <= 16'd0;
        end else if (pipe_valid) begin
            regWrite <= 1'b1;
            wr_r0    <= 1'b0;
            WA       <= pipe_wa;
            WD1      <= pipe_data;
            WD0      <= 16'd0;
        end else if (!empty) begin
            regWrite <= 1'b1;
            wr_r0    <= 1'b1;
            WA       <= ent_wa[rd_ptr];
            WD1      <= ent_lo[rd_ptr];
            WD0      <= ent_hi[rd_ptr];
        end else if (md_valid) begin
            regWrite <= 1'b1;
            wr_r0    <= 1'b1;
            WA       <= md_wa;
            WD1      <= md_lo;
            WD0      <= md_hi;
        end else begin
            regWrite <= 1'b0;
        end
    end

`ifdef WB_FWD_EN
    // same-cycle bypass of the write currently on the port
    assign fwd1_hit  = regWrite && (WA == RR1 || (wr_r0 && RR1 == 4'd0));
    assign fwd2_hit  = regWrite && (WA == RR2 || (wr_r0 && RR2 == 4'd0));
    assign fwd1_data = (RR1 == 4'd0 && wr_r0) ? WD0 : WD1;
    assign fwd2_data = (RR2 == 4'd0 && wr_r0) ? WD0 : WD1;
`else
    // decode relies on register file write-before-read timing
`endif

endmodule

// File: tb/tb_wb_write_ctrl.sv
// tb/tb_wb_write_ctrl.sv - scoreboard bench for wb_write_ctrl
module tb_wb_write_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_valid, pipe_is_load, pipe_lb;
    logic [3:0]  pipe_wa;
    logic [15:0] pipe_wd;
    logic        md_valid, md_ready;
    logic [3:0]  md_wa;
    logic [15:0] md_lo, md_hi;
    logic [3:0]  RR1, RR2;
    logic        hazard, regWrite, wr_r0;
    logic [3:0]  WA;
    logic [15:0] WD1, WD0;

    typedef struct packed {
        logic [3:0]  wa;
        logic [15:0] wd1;
        logic [15:0] wd0;
        logic        r0;
    } wr_t;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    wb_write_ctrl #(.DEPTH(2), .PTR_W(1)) dut (
        .clk(clk), .rst(rst),
        .pipe_valid(pipe_valid), .pipe_is_load(pipe_is_load), .pipe_lb(pipe_lb),
        .pipe_wa(pipe_wa), .pipe_wd(pipe_wd),
        .md_valid(md_valid), .md_ready(md_ready), .md_wa(md_wa),
        .md_lo(md_lo), .md_hi(md_hi),
        .RR1(RR1), .RR2(RR2), .hazard(hazard),
        .regWrite(regWrite), .wr_r0(wr_r0), .WA(WA), .WD1(WD1), .WD0(WD0)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic exp_wr(input logic [3:0] wa, input logic [15:0] wd1,
                          input logic [15:0] wd0, input logic r0);
        exp_q.push_back('{wa: wa, wd1: wd1, wd0: wd0, r0: r0});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // monitor: every write on the port must match the next scoreboard entry
    always @(negedge clk) begin
        if (regWrite) begin
            wr_t got, want;
            got = '{wa: WA, wd1: WD1, wd0: WD0, r0: wr_r0};
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got %h expected no write", got);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    n_fail++;
                    $display("FAIL write: got wa=%h wd1=%h wd0=%h r0=%b expected wa=%h wd1=%h wd0=%h r0=%b",
                             got.wa, got.wd1, got.wd0, got.r0, want.wa, want.wd1, want.wd0, want.r0);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        pipe_valid = 1'b1; pipe_is_load = 1'b0; pipe_lb = 1'b0;
        pipe_wa = 4'd7; pipe_wd = 16'h7777;
        md_valid = 1'b0; md_wa = 4'd0; md_lo = 16'd0; md_hi = 16'd0;
        RR1 = 4'd0; RR2 = 4'd0;

        // reset held two cycles with a pipeline result present
        tick(); tick();
        check("rst_regWrite", {15'd0, regWrite}, 16'd0);
        check("rst_wr_r0", {15'd0, wr_r0}, 16'd0);
        check("rst_WA", {12'd0, WA}, 16'd0);
        check("rst_WD1", WD1, 16'd0);
        check("rst_WD0", WD0, 16'd0);
        rst = 1'b0; pipe_valid = 1'b0;
        #1;
        check("rst_md_ready", {15'd0, md_ready}, 16'd1);
        check("rst_hazard", {15'd0, hazard}, 16'd0);

        // ALU, byte load, word load, ALU with stray lb
        pipe_valid = 1'b1; pipe_wa = 4'd3; pipe_wd = 16'h0005;
        exp_wr(4'd3, 16'h0005, 16'h0000, 1'b0);
        tick();
        pipe_is_load = 1'b1; pipe_lb = 1'b1; pipe_wa = 4'd4; pipe_wd = 16'h1280;
        exp_wr(4'd4, 16'hFF80, 16'h0000, 1'b0);
        tick();
        pipe_lb = 1'b0; pipe_wa = 4'd6; pipe_wd = 16'h1280;
        exp_wr(4'd6, 16'h1280, 16'h0000, 1'b0);
        tick();
        pipe_is_load = 1'b0; pipe_lb = 1'b1; pipe_wa = 4'd7; pipe_wd = 16'h00F0;
        exp_wr(4'd7, 16'h00F0, 16'h0000, 1'b0);
        tick();
        pipe_valid = 1'b0; pipe_lb = 1'b0;
        tick();

        // idle mul/div bypass, then idle hold
        md_valid = 1'b1; md_wa = 4'd10; md_lo = 16'h0008; md_hi = 16'h0001;
        #1;
        check("bypass_md_ready", {15'd0, md_ready}, 16'd1);
        exp_wr(4'd10, 16'h0008, 16'h0001, 1'b1);
        tick();
        md_valid = 1'b0;
        tick();
        check("hold_regWrite", {15'd0, regWrite}, 16'd0);
        check("hold_WA", {12'd0, WA}, 16'd10);
        check("hold_WD1", WD1, 16'h0008);
        RR1 = 4'd10; RR2 = 4'd9;
        #1;
        check("bypass_no_hazard", {15'd0, hazard}, 16'd0);

        // collision: pipeline first, mul/div next cycle
        pipe_valid = 1'b1; pipe_wa = 4'd2; pipe_wd = 16'h1111;
        md_valid = 1'b1; md_wa = 4'd5; md_lo = 16'h2222; md_hi = 16'h3333;
        exp_wr(4'd2, 16'h1111, 16'h0000, 1'b0);
        exp_wr(4'd5, 16'h2222, 16'h3333, 1'b1);
        tick();
        pipe_valid = 1'b0; md_valid = 1'b0;
        RR1 = 4'd5; RR2 = 4'd9;
        #1;
        check("coll_hazard_rr1", {15'd0, hazard}, 16'd1);
        RR1 = 4'd9; RR2 = 4'd0;
        #1;
        check("coll_hazard_r0", {15'd0, hazard}, 16'd1);
        RR1 = 4'd9; RR2 = 4'd8;
        #1;
        check("coll_hazard_none", {15'd0, hazard}, 16'd0);
        tick();
        RR2 = 4'd0;
        #1;
        check("drained_hazard", {15'd0, hazard}, 16'd0);
        tick();

        // fill to full under a busy pipeline, then full+pop on the release cycle
        md_valid = 1'b1; md_wa = 4'd11; md_lo = 16'hB001; md_hi = 16'hC001;
        for (int i = 1; i <= 4; i++) begin
            pipe_valid = 1'b1; pipe_wa = 4'(i); pipe_wd = 16'hA000 + 16'(i);
            exp_wr(4'(i), 16'hA000 + 16'(i), 16'h0000, 1'b0);
            #1;
            if (i >= 3) check("full_md_ready", {15'd0, md_ready}, 16'd0);
            tick();
            if (i == 1) begin
                md_wa = 4'd12; md_lo = 16'hB002; md_hi = 16'hC002;
            end else if (i == 2) begin
                md_wa = 4'd13; md_lo = 16'hB003; md_hi = 16'hC003;
            end
        end
        exp_wr(4'd11, 16'hB001, 16'hC001, 1'b1);
        exp_wr(4'd12, 16'hB002, 16'hC002, 1'b1);
        exp_wr(4'd13, 16'hB003, 16'hC003, 1'b1);
        pipe_valid = 1'b0;
        #1;
        check("full_pop_md_ready", {15'd0, md_ready}, 16'd1);
        tick();
        md_valid = 1'b0;
        tick(); tick(); tick();
        check("drain_md_ready", {15'd0, md_ready}, 16'd1);

        // reset with two pending entries drops them
        md_valid = 1'b1;
        pipe_valid = 1'b1; pipe_wa = 4'd1; pipe_wd = 16'h0101;
        md_wa = 4'd14; md_lo = 16'hE0E0; md_hi = 16'hE1E1;
        exp_wr(4'd1, 16'h0101, 16'h0000, 1'b0);
        tick();
        pipe_wa = 4'd2; pipe_wd = 16'h0202;
        md_wa = 4'd15; md_lo = 16'hF0F0; md_hi = 16'hF1F1;
        exp_wr(4'd2, 16'h0202, 16'h0000, 1'b0);
        tick();
        pipe_valid = 1'b0; md_valid = 1'b0;
        RR1 = 4'd14; RR2 = 4'd9;
        #1;
        check("pre_rst_hazard", {15'd0, hazard}, 16'd1);
        check("pre_rst_md_ready", {15'd0, md_ready}, 16'd1);
        rst = 1'b1;
        tick();
        check("rst_drain_regWrite0", {15'd0, regWrite}, 16'd0);
        rst = 1'b0;
        RR2 = 4'd0;
        #1;
        check("rst_drain_hazard", {15'd0, hazard}, 16'd0);
        tick();
        check("rst_drain_regWrite1", {15'd0, regWrite}, 16'd0);
        tick();

        // every expected write must have appeared within a bounded window
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
        check("scoreboard_empty", 16'(exp_q.size()), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
